// File: rtl/host_descriptor_arbiter.sv
// rtl/host_descriptor_arbiter.sv - two-requester descriptor arbiter feeding host queue management
module host_descriptor_arbiter #(
  parameter int TAG_W        = 48,
  parameter int BUFID_W      = 9,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [TAG_W-1:0]           iv_tsntag_hcp,
  input  logic [BUFID_W-1:0]         iv_bufid_hcp,
  input  logic                       i_descriptor_wr_hcp,
  output logic                       o_descriptor_ack_hcp,
  input  logic [TAG_W-1:0]           iv_tsntag_network,
  input  logic [BUFID_W-1:0]         iv_bufid_network,
  input  logic                       i_descriptor_wr_network,
  output logic                       o_descriptor_ack_network,
  output logic [TAG_W+BUFID_W-1:0]   ov_descriptor,
  output logic                       o_descriptor_src,
  output logic                       o_descriptor_wr,
  input  logic                       i_descriptor_ready,
  output logic [15:0]                ov_grant_cnt_hcp,
  output logic [15:0]                ov_grant_cnt_network,
  output logic [1:0]                 ov_arb_state
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;

  state_t      state;
  logic        rr_network;    // 0: HCP wins the next tie, 1: network wins it
  logic [3:0]  starve_cnt;    // consecutive HCP grants while network was waiting
  logic [15:0] cnt_hcp;
  logic [15:0] cnt_network;

  logic in_idle;
  logic any_req;
  logic tie_to_network;
  logic pick_network;

  // Anything other than SEND (including the unused encodings) behaves as IDLE
  assign in_idle = (state != SEND);
  assign any_req = i_descriptor_wr_hcp | i_descriptor_wr_network;

  // Tie-break: rotating pointer, or HCP first until network has waited STARVE_LIMIT grants
  assign tie_to_network = (PRIO_MODE == 0) ? rr_network : (starve_cnt == STARVE_MAX);
  assign pick_network   = i_descriptor_wr_network & (~i_descriptor_wr_hcp | tie_to_network);

  assign ov_grant_cnt_hcp     = cnt_hcp;
  assign ov_grant_cnt_network = cnt_network;
  assign ov_arb_state         = state;

  // Arbitration FSM: grant and latch in IDLE, hold the descriptor in SEND until accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                    <= IDLE;
      rr_network               <= 1'b0;
      starve_cnt               <= '0;
      cnt_hcp                  <= '0;
      cnt_network              <= '0;
      o_descriptor_ack_hcp     <= 1'b0;
      o_descriptor_ack_network <= 1'b0;
      ov_descriptor            <= '0;
      o_descriptor_src         <= 1'b0;
      o_descriptor_wr          <= 1'b0;
    end else begin
      o_descriptor_ack_hcp     <= 1'b0;
      o_descriptor_ack_network <= 1'b0;
      if (in_idle) begin
        state <= IDLE;
        if (any_req) begin
          state            <= SEND;
          o_descriptor_wr  <= 1'b1;
          o_descriptor_src <= pick_network;
          if (pick_network) begin
            ov_descriptor            <= {iv_tsntag_network, iv_bufid_network};
            o_descriptor_ack_network <= 1'b1;
            cnt_network              <= cnt_network + 16'd1;
          end else begin
            ov_descriptor        <= {iv_tsntag_hcp, iv_bufid_hcp};
            o_descriptor_ack_hcp <= 1'b1;
            cnt_hcp              <= cnt_hcp + 16'd1;
          end
          // The loser of a tie becomes the preferred side next time
          if (i_descriptor_wr_hcp && i_descriptor_wr_network) begin
            rr_network <= ~pick_network;
          end
        end
        if (PRIO_MODE != 0) begin
          if (!i_descriptor_wr_network || pick_network) begin
            starve_cnt <= '0;
          end else if (i_descriptor_wr_hcp && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
      end else if (o_descriptor_wr && i_descriptor_ready) begin
        o_descriptor_wr <= 1'b0;
        state           <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_host_descriptor_arbiter.sv
// tb/tb_host_descriptor_arbiter.sv - vector table plus scoreboard bench for host_descriptor_arbiter
module tb_host_descriptor_arbiter;

  localparam logic [47:0] TA  = 48'h0000_0000_00A5;
  localparam logic [8:0]  BA  = 9'h01F;
  localparam logic [47:0] TN1 = 48'h1234_5678_9ABC;
  localparam logic [8:0]  BN1 = 9'h155;
  localparam logic [47:0] TN2 = 48'h0BAD_F00D_0001;
  localparam logic [8:0]  BN2 = 9'h0AA;
  localparam logic [47:0] TH2 = 48'h7777_0000_0042;
  localparam logic [8:0]  BH2 = 9'h0C3;
  localparam logic [47:0] TN3 = 48'h5555_AAAA_0003;
  localparam logic [8:0]  BN3 = 9'h03C;
  localparam logic [47:0] TAGH_BASE = 48'hC0DE_0000_0000;
  localparam logic [47:0] TAGN_BASE = 48'hBEEF_0000_0000;

  logic        clk;
  logic        rst;
  logic [47:0] tag_h, tag_n;
  logic [8:0]  buf_h, buf_n;
  logic        wr_h, wr_n, ready;

  logic        rr_ack_h, rr_ack_n, rr_src, rr_wr;
  logic [56:0] rr_desc;
  logic [15:0] rr_cnt_h, rr_cnt_n;
  logic [1:0]  rr_state;
  logic        pr_ack_h, pr_ack_n, pr_src, pr_wr;
  logic [56:0] pr_desc;
  logic [15:0] pr_cnt_h, pr_cnt_n;
  logic [1:0]  pr_state;

  int vectors;
  int miscompares;
  logic [57:0] sbq[$];

  host_descriptor_arbiter #(.PRIO_MODE(0)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .iv_tsntag_hcp(tag_h), .iv_bufid_hcp(buf_h), .i_descriptor_wr_hcp(wr_h),
    .o_descriptor_ack_hcp(rr_ack_h),
    .iv_tsntag_network(tag_n), .iv_bufid_network(buf_n), .i_descriptor_wr_network(wr_n),
    .o_descriptor_ack_network(rr_ack_n),
    .ov_descriptor(rr_desc), .o_descriptor_src(rr_src), .o_descriptor_wr(rr_wr),
    .i_descriptor_ready(ready),
    .ov_grant_cnt_hcp(rr_cnt_h), .ov_grant_cnt_network(rr_cnt_n), .ov_arb_state(rr_state)
  );

  host_descriptor_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(2)) dut_pr (
    .i_clk(clk), .i_rst(rst),
    .iv_tsntag_hcp(tag_h), .iv_bufid_hcp(buf_h), .i_descriptor_wr_hcp(wr_h),
    .o_descriptor_ack_hcp(pr_ack_h),
    .iv_tsntag_network(tag_n), .iv_bufid_network(buf_n), .i_descriptor_wr_network(wr_n),
    .o_descriptor_ack_network(pr_ack_n),
    .ov_descriptor(pr_desc), .o_descriptor_src(pr_src), .o_descriptor_wr(pr_wr),
    .i_descriptor_ready(ready),
    .ov_grant_cnt_hcp(pr_cnt_h), .ov_grant_cnt_network(pr_cnt_n), .ov_arb_state(pr_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_h, wr_n, ready;
    logic [47:0] tag_h;
    logic [8:0]  buf_h;
    logic [47:0] tag_n;
    logic [8:0]  buf_n;
    logic        e_ack_h, e_ack_n, e_wr, e_src, chk_desc;
    logic [56:0] e_desc;
    logic [1:0]  e_state;
    logic [15:0] e_cnt_h, e_cnt_n;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_h = 1'b0; wr_n = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [57:0] exp_h(input int k);
    return {1'b0, TAGH_BASE + 48'(k), 9'h100 | 9'(k)};
  endfunction

  function automatic logic [57:0] exp_n(input int k);
    return {1'b1, TAGN_BASE + 48'(k), 9'(k)};
  endfunction

  // Both requesters present fresh data after every ack; transfers are checked against sbq
  task automatic run_sb(input bit use_pr, input int nh, input int nn);
    int sh, sn, got, total;
    logic s_wr, s_src, s_ack_h, s_ack_n;
    logic [56:0] s_desc;
    logic [57:0] e;
    sh = 0; sn = 0; got = 0; total = nh + nn;
    tag_h = TAGH_BASE; buf_h = 9'h100; wr_h = (nh > 0);
    tag_n = TAGN_BASE; buf_n = 9'h000; wr_n = (nn > 0);
    ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < total; cyc++) begin
      @(posedge clk); #1;
      s_wr    = use_pr ? pr_wr    : rr_wr;
      s_src   = use_pr ? pr_src   : rr_src;
      s_desc  = use_pr ? pr_desc  : rr_desc;
      s_ack_h = use_pr ? pr_ack_h : rr_ack_h;
      s_ack_n = use_pr ? pr_ack_n : rr_ack_n;
      if (s_wr && ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_transfer", 64'(got), 64'(total));
        end else begin
          e = sbq.pop_front();
          chk("sb_descriptor", 64'({s_src, s_desc}), 64'(e));
        end
        got++;
      end
      if (s_ack_h) begin
        sh++;
        wr_h  = (sh < nh);
        tag_h = TAGH_BASE + 48'(sh);
        buf_h = 9'h100 | 9'(sh);
      end
      if (s_ack_n) begin
        sn++;
        wr_n  = (sn < nn);
        tag_n = TAGN_BASE + 48'(sn);
        buf_n = 9'(sn);
      end
    end
    chk("sb_transfers_done", 64'(got), 64'(total));
    chk("sb_queue_empty", 64'(sbq.size()), 64'd0);
    sbq.delete();
    wr_h = 1'b0; wr_n = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clk = 1'b0;
    tag_h = '0; buf_h = '0; tag_n = '0; buf_n = '0;

    // fields: wr_h wr_n ready tag_h buf_h tag_n buf_n | ack_h ack_n wr src chk_desc desc state cnt_h cnt_n
    vt[0]  = '{0,0,1, 48'h0,9'h0, 48'h0,9'h0, 0,0,0,0,0, 57'h0,           2'd0, 16'd0,16'd0};
    vt[1]  = '{1,0,1, TA,BA,      48'h0,9'h0, 1,0,1,0,1, {TA,BA},         2'd1, 16'd1,16'd0};
    vt[2]  = '{0,0,1, 48'h0,9'h0, 48'h0,9'h0, 0,0,0,0,0, 57'h0,           2'd0, 16'd1,16'd0};
    vt[3]  = '{0,1,0, 48'h0,9'h0, TN1,BN1,    0,1,1,1,1, {TN1,BN1},       2'd1, 16'd1,16'd1};
    vt[4]  = '{0,0,0, 48'h0,9'h0, 48'h0,9'h0, 0,0,1,1,1, {TN1,BN1},       2'd1, 16'd1,16'd1};
    vt[5]  = '{0,1,0, 48'h0,9'h0, TN2,BN2,    0,0,1,1,1, {TN1,BN1},       2'd1, 16'd1,16'd1};
    vt[6]  = '{0,1,1, 48'h0,9'h0, TN2,BN2,    0,0,0,0,0, 57'h0,           2'd0, 16'd1,16'd1};
    vt[7]  = '{0,1,0, 48'h0,9'h0, TN2,BN2,    0,1,1,1,1, {TN2,BN2},       2'd1, 16'd1,16'd2};
    vt[8]  = '{0,0,1, 48'h0,9'h0, 48'h0,9'h0, 0,0,0,0,0, 57'h0,           2'd0, 16'd1,16'd2};
    vt[9]  = '{1,1,1, TH2,BH2,    TN3,BN3,    1,0,1,0,1, {TH2,BH2},       2'd1, 16'd2,16'd2};
    vt[10] = '{0,1,1, 48'h0,9'h0, TN3,BN3,    0,0,0,0,0, 57'h0,           2'd0, 16'd2,16'd2};
    vt[11] = '{0,1,1, 48'h0,9'h0, TN3,BN3,    0,1,1,1,1, {TN3,BN3},       2'd1, 16'd2,16'd3};
    vt[12] = '{0,0,1, 48'h0,9'h0, 48'h0,9'h0, 0,0,0,0,0, 57'h0,           2'd0, 16'd2,16'd3};

    // reset state
    rst = 1'b1; wr_h = 1'b0; wr_n = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_wr",    64'(rr_wr), 64'd0);
    chk("reset_acks",  64'({rr_ack_h, rr_ack_n}), 64'd0);
    chk("reset_desc",  64'({rr_src, rr_desc}), 64'd0);
    chk("reset_state", 64'(rr_state), 64'd0);
    chk("reset_cnts",  64'({rr_cnt_h, rr_cnt_n}), 64'd0);
    rst = 1'b0;

    // single requests, stalls, ignored wr in SEND, round-robin tie
    for (int i = 0; i < 13; i++) begin
      wr_h = vt[i].wr_h; wr_n = vt[i].wr_n; ready = vt[i].ready;
      tag_h = vt[i].tag_h; buf_h = vt[i].buf_h; tag_n = vt[i].tag_n; buf_n = vt[i].buf_n;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack_h", i), 64'(rr_ack_h), 64'(vt[i].e_ack_h));
      chk($sformatf("v%0d_ack_n", i), 64'(rr_ack_n), 64'(vt[i].e_ack_n));
      chk($sformatf("v%0d_wr", i),    64'(rr_wr),    64'(vt[i].e_wr));
      chk($sformatf("v%0d_state", i), 64'(rr_state), 64'(vt[i].e_state));
      chk($sformatf("v%0d_cnts", i),  64'({rr_cnt_h, rr_cnt_n}), 64'({vt[i].e_cnt_h, vt[i].e_cnt_n}));
      if (vt[i].chk_desc) begin
        chk($sformatf("v%0d_desc", i), 64'({rr_src, rr_desc}), 64'({vt[i].e_src, vt[i].e_desc}));
      end
    end

    // round-robin with both held: H,N,H,N,H,N
    do_reset();
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(exp_h(k));
      sbq.push_back(exp_n(k));
    end
    run_sb(1'b0, 3, 3);
    chk("rr_cnt_hcp", 64'(rr_cnt_h), 64'd3);
    chk("rr_cnt_net", 64'(rr_cnt_n), 64'd3);

    // HCP priority, starve limit 2: H,H,N,H,H,N
    do_reset();
    sbq.push_back(exp_h(0)); sbq.push_back(exp_h(1)); sbq.push_back(exp_n(0));
    sbq.push_back(exp_h(2)); sbq.push_back(exp_h(3)); sbq.push_back(exp_n(1));
    run_sb(1'b1, 4, 2);
    chk("pr_cnt_hcp", 64'(pr_cnt_h), 64'd4);
    chk("pr_cnt_net", 64'(pr_cnt_n), 64'd2);

    // downstream stall of 10 cycles after grant
    do_reset();
    tag_h = 48'hFEED_0000_0004; buf_h = 9'h004; wr_h = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    chk("stall_grant_ack", 64'(rr_ack_h), 64'd1);
    wr_h = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_hold", i), 64'({rr_wr, rr_ack_h, rr_ack_n, rr_state}), 64'({1'b1, 1'b0, 1'b0, 2'd1}));
      chk($sformatf("stall%0d_desc", i), 64'(rr_desc), 64'({48'hFEED_0000_0004, 9'h004}));
    end
    ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 64'({rr_wr, rr_state}), 64'({1'b0, 2'd0}));

    // reset while in SEND aborts the descriptor; re-arbitration is HCP-first
    do_reset();
    tag_h = TH2; buf_h = BH2; tag_n = TN3; buf_n = BN3;
    wr_h = 1'b1; wr_n = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_send_state", 64'(rr_state), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_send_out", 64'({rr_wr, rr_ack_h, rr_ack_n, rr_state}), 64'd0);
    chk("rst_send_cnt", 64'({rr_cnt_h, rr_cnt_n}), 64'd0);
    rst = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_regrant_h", 64'({rr_ack_h, rr_ack_n, rr_src, rr_desc}), 64'({1'b1, 1'b0, 1'b0, TH2, BH2}));
    wr_h = 1'b0;
    @(posedge clk); #1;
    chk("rst_xfer_h", 64'(rr_wr), 64'd0);
    @(posedge clk); #1;
    chk("rst_regrant_n", 64'({rr_ack_n, rr_src, rr_desc}), 64'({1'b1, 1'b1, TN3, BN3}));
    wr_n = 1'b0;
    @(posedge clk); #1;

    // network grant counter wraps from 0xFFFF
    do_reset();
    @(negedge clk);
    force dut_rr.cnt_network = 16'hFFFF;
    #1;
    release dut_rr.cnt_network;
    #1;
    chk("wrap_preload", 64'(rr_cnt_n), 64'hFFFF);
    tag_n = TN1; buf_n = BN1; wr_n = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    chk("wrap_ack", 64'(rr_ack_n), 64'd1);
    chk("wrap_cnt_net", 64'(rr_cnt_n), 64'h0000);
    chk("wrap_cnt_hcp", 64'(rr_cnt_h), 64'h0000);
    wr_n = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
